// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, opcode validity rule and issuer FSM encoding
package alu_pkg;

    localparam logic [7:0] OP_ADD = 8'd0;
    localparam logic [7:0] OP_SUB = 8'd1;
    localparam logic [7:0] OP_OR  = 8'd2;
    localparam logic [7:0] OP_AND = 8'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESPOND   = 3'd4
    } issuer_state_t;

    // The ALU only implements the four opcodes above; anything larger is rejected.
    function automatic logic op_is_legal(input logic [7:0] op);
        return op <= OP_AND;
    endfunction

endpackage

// File: rtl/alu_issuer_if.sv
// rtl/alu_issuer_if.sv - command, ALU and response signals of the ALU issuer
interface alu_issuer_if #(
    parameter int TAG_W = 4
);
    logic             in_wire_cmd_valid;
    logic             out_wire_cmd_ready;
    logic [7:0]       in_wire_cmd_op;
    logic [7:0]       in_wire_cmd_a;
    logic [7:0]       in_wire_cmd_b;
    logic [TAG_W-1:0] in_wire_cmd_tag;
    logic             out_wire_enable;
    logic [7:0]       out_wire_instruction;
    logic [7:0]       out_wire_input_0;
    logic [7:0]       out_wire_input_1;
    logic             in_wire_busy;
    logic [7:0]       in_wire_result;
    logic             out_wire_rsp_valid;
    logic             in_wire_rsp_ready;
    logic [7:0]       out_wire_rsp_data;
    logic [TAG_W-1:0] out_wire_rsp_tag;
    logic             out_wire_rsp_error;
    logic             out_wire_idle;

    // Issuer side
    modport master (
        input  in_wire_cmd_valid, in_wire_cmd_op, in_wire_cmd_a, in_wire_cmd_b,
               in_wire_cmd_tag, in_wire_busy, in_wire_result, in_wire_rsp_ready,
        output out_wire_cmd_ready, out_wire_enable, out_wire_instruction,
               out_wire_input_0, out_wire_input_1, out_wire_rsp_valid,
               out_wire_rsp_data, out_wire_rsp_tag, out_wire_rsp_error, out_wire_idle
    );

    // Sequencer / ALU / response consumer side
    modport slave (
        output in_wire_cmd_valid, in_wire_cmd_op, in_wire_cmd_a, in_wire_cmd_b,
               in_wire_cmd_tag, in_wire_busy, in_wire_result, in_wire_rsp_ready,
        input  out_wire_cmd_ready, out_wire_enable, out_wire_instruction,
               out_wire_input_0, out_wire_input_1, out_wire_rsp_valid,
               out_wire_rsp_data, out_wire_rsp_tag, out_wire_rsp_error, out_wire_idle
    );
endinterface

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous command FIFO with wrap-bit pointers and full/empty flags
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 28
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Same index with opposite wrap bits means the writer has lapped the reader.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; wrap-around is silent.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset because empty gates every read.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/alu_issuer.sv
// rtl/alu_issuer.sv - ALU issuer top; ALU_ISSUER_TIMEOUT_EN adds a wait-state timeout
module alu_issuer
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TAG_W          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input logic          clk,
    input logic          reset,
    alu_issuer_if.master bus
);
    localparam int CMD_W = 24 + TAG_W;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("alu_issuer: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    issuer_state_t    state;
    logic [CMD_W-1:0] fifo_wdata;
    logic [CMD_W-1:0] fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [7:0]       head_op;
    logic [7:0]       op_q;
    logic [7:0]       a_q;
    logic [7:0]       b_q;
    logic [TAG_W-1:0] tag_q;
    logic             enable_q;
    logic             rsp_valid_q;
    logic [7:0]       rsp_data_q;
    logic             rsp_error_q;

`ifdef ALU_ISSUER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] wait_cnt;
    logic            wait_expired;
    // wait_cnt holds the cycles already spent in the current wait state, so
    // this cycle is the TIMEOUT_CYCLES-th one when it equals TIMEOUT_CYCLES-1.
    assign wait_expired = (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    // Without the timeout both wait states block until the ALU answers.
`endif

    assign fifo_wdata = {bus.in_wire_cmd_tag, bus.in_wire_cmd_op, bus.in_wire_cmd_a, bus.in_wire_cmd_b};
    assign push       = bus.in_wire_cmd_valid && !fifo_full;
    assign pop        = (state == ST_IDLE) && !fifo_empty;
    assign head_op    = fifo_rdata[23:16];

    alu_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (fifo_wdata),
        .pop     (pop),
        .rd_data (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign bus.out_wire_cmd_ready   = !fifo_full;
    assign bus.out_wire_idle        = (state == ST_IDLE) && fifo_empty;
    assign bus.out_wire_enable      = enable_q;
    assign bus.out_wire_instruction = op_q;
    assign bus.out_wire_input_0     = a_q;
    assign bus.out_wire_input_1     = b_q;
    assign bus.out_wire_rsp_valid   = rsp_valid_q;
    assign bus.out_wire_rsp_data    = rsp_data_q;
    assign bus.out_wire_rsp_tag     = tag_q;
    assign bus.out_wire_rsp_error   = rsp_error_q;

    // Issuer FSM: pop a command, drive the ALU through its busy handshake, hold the response.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            tag_q       <= '0;
            enable_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
`ifdef ALU_ISSUER_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        op_q  <= head_op;
                        a_q   <= fifo_rdata[15:8];
                        b_q   <= fifo_rdata[7:0];
                        tag_q <= fifo_rdata[CMD_W-1:24];
                        if (op_is_legal(head_op)) begin
                            enable_q <= 1'b1;
                            state    <= ST_ISSUE;
                        end else begin
                            // Illegal opcodes never reach the ALU.
                            rsp_valid_q <= 1'b1;
                            rsp_error_q <= 1'b1;
                            rsp_data_q  <= '0;
                            state       <= ST_RESPOND;
                        end
                    end
                end
                ST_ISSUE: begin
`ifdef ALU_ISSUER_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (bus.in_wire_busy) begin
`ifdef ALU_ISSUER_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                        state <= ST_WAIT_DONE;
                    end
`ifdef ALU_ISSUER_TIMEOUT_EN
                    else if (wait_expired) begin
                        enable_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= 1'b1;
                        rsp_data_q  <= '0;
                        state       <= ST_RESPOND;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
`endif
                end
                ST_WAIT_DONE: begin
                    if (!bus.in_wire_busy) begin
                        enable_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= bus.in_wire_result;
                        state       <= ST_RESPOND;
                    end
`ifdef ALU_ISSUER_TIMEOUT_EN
                    else if (wait_expired) begin
                        enable_q    <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_error_q <= 1'b1;
                        rsp_data_q  <= '0;
                        state       <= ST_RESPOND;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
`endif
                end
                ST_RESPOND: begin
                    // The next pop happens one cycle after accept, never in the accept cycle.
                    if (bus.in_wire_rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        rsp_error_q <= 1'b0;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
